// File: rtl/pkt_read_responder_pkg.sv
// Shared widths and types for the packet read responder and its arbiters.
// Two transmit ports share one packet RAM read path and one free-list write path.
package pkt_read_responder_pkg;

   localparam int BUFID_W = 9;
   localparam int RADDR_W = 16;
   localparam int DATA_W  = 134;
   localparam int NPORT   = 2;

   typedef logic [BUFID_W-1:0] bufid_t;
   typedef logic [RADDR_W-1:0] raddr_t;
   typedef logic [DATA_W-1:0]  data_t;

   // Travels beside each RAM read so the returning word finds its port.
   typedef struct packed {
      logic vld;
      logic port;
   } rd_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// 2-way round-robin arbiter: grant registered one cycle after the request sample,
// the port holding the registered grant is masked that cycle; no backpressure.
module rr_arb2
   import pkt_read_responder_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [NPORT-1:0] i_req,
   output logic [NPORT-1:0] o_gnt_nxt,
   output logic [NPORT-1:0] o_gnt
);

   logic             r_prio;
   logic [NPORT-1:0] r_gnt;
   logic [NPORT-1:0] w_req;
   logic [NPORT-1:0] w_gnt;

   // A requester sees its ack one cycle late, so its request is still high then.
   always_comb begin
      w_req = i_req & ~r_gnt;
      w_gnt = '0;
      if (w_req == 2'b11) begin
         w_gnt[r_prio] = 1'b1;
      end else begin
         w_gnt = w_req;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_prio <= 1'b0;
         r_gnt  <= '0;
      end else begin
         r_gnt <= w_gnt;
         if (|w_gnt) begin
            r_prio <= w_gnt[0];
         end
      end
   end

   assign o_gnt_nxt = w_gnt;
   assign o_gnt     = r_gnt;

endmodule

// File: rtl/pkt_read_responder.sv
// Arbitrates two ports onto one packet-RAM read path and one free-list path.
// Read data returns 2+RAM_LAT cycles after the request sample; requests hold until acked.
module pkt_read_responder
   import pkt_read_responder_pkg::*;
#(
   parameter int RAM_LAT = 1
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [BUFID_W-1:0] iv_pkt_bufid_p0,
   input  logic [BUFID_W-1:0] iv_pkt_bufid_p1,
   input  logic               i_pkt_bufid_wr_p0,
   input  logic               i_pkt_bufid_wr_p1,
   output logic               o_pkt_bufid_ack_p0,
   output logic               o_pkt_bufid_ack_p1,
   input  logic [RADDR_W-1:0] iv_pkt_raddr_p0,
   input  logic [RADDR_W-1:0] iv_pkt_raddr_p1,
   input  logic               i_pkt_rd_p0,
   input  logic               i_pkt_rd_p1,
   output logic               o_pkt_raddr_ack_p0,
   output logic               o_pkt_raddr_ack_p1,
   output logic [DATA_W-1:0]  ov_pkt_data_p0,
   output logic [DATA_W-1:0]  ov_pkt_data_p1,
   output logic               o_pkt_data_wr_p0,
   output logic               o_pkt_data_wr_p1,
   output logic [RADDR_W-1:0] ov_ram_raddr,
   output logic               o_ram_rd,
   input  logic [DATA_W-1:0]  iv_ram_rdata,
   output logic [BUFID_W-1:0] ov_free_bufid,
   output logic               o_free_bufid_wr
);

   logic [NPORT-1:0] w_rd_gnt_nxt;
   logic [NPORT-1:0] w_rd_gnt;
   logic [NPORT-1:0] w_rel_gnt_nxt;
   logic [NPORT-1:0] w_rel_gnt;
   logic             w_ram_rd;
   rd_tag_t          w_tag_out;

   raddr_t  r_ram_raddr;
   bufid_t  r_free_bufid;
   data_t   r_data_p0;
   data_t   r_data_p1;
   logic    r_data_wr_p0;
   logic    r_data_wr_p1;
   rd_tag_t r_tag [RAM_LAT];

   rr_arb2 u_rd_arb (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_req     ({i_pkt_rd_p1, i_pkt_rd_p0}),
      .o_gnt_nxt (w_rd_gnt_nxt),
      .o_gnt     (w_rd_gnt)
   );

   rr_arb2 u_rel_arb (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_req     ({i_pkt_bufid_wr_p1, i_pkt_bufid_wr_p0}),
      .o_gnt_nxt (w_rel_gnt_nxt),
      .o_gnt     (w_rel_gnt)
   );

   assign w_ram_rd  = |w_rd_gnt;
   assign w_tag_out = r_tag[RAM_LAT-1];

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_ram_raddr  <= '0;
         r_free_bufid <= '0;
      end else begin
         if (|w_rd_gnt_nxt) begin
            r_ram_raddr <= w_rd_gnt_nxt[1] ? iv_pkt_raddr_p1 : iv_pkt_raddr_p0;
         end
         if (|w_rel_gnt_nxt) begin
            r_free_bufid <= w_rel_gnt_nxt[1] ? iv_pkt_bufid_p1 : iv_pkt_bufid_p0;
         end
      end
   end

   // Clearing the tags on reset drops any read still inside the RAM.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int i = 0; i < RAM_LAT; i++) begin
            r_tag[i] <= '0;
         end
      end else begin
         r_tag[0] <= rd_tag_t'{vld: w_ram_rd, port: w_rd_gnt[1]};
         for (int i = 1; i < RAM_LAT; i++) begin
            r_tag[i] <= r_tag[i-1];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_data_p0    <= '0;
         r_data_p1    <= '0;
         r_data_wr_p0 <= 1'b0;
         r_data_wr_p1 <= 1'b0;
      end else begin
         r_data_wr_p0 <= w_tag_out.vld && !w_tag_out.port;
         r_data_wr_p1 <= w_tag_out.vld &&  w_tag_out.port;
         if (w_tag_out.vld && !w_tag_out.port) begin
            r_data_p0 <= iv_ram_rdata;
         end
         if (w_tag_out.vld && w_tag_out.port) begin
            r_data_p1 <= iv_ram_rdata;
         end
      end
   end

   assign o_pkt_raddr_ack_p0 = w_rd_gnt[0];
   assign o_pkt_raddr_ack_p1 = w_rd_gnt[1];
   assign o_ram_rd           = w_ram_rd;
   assign ov_ram_raddr       = r_ram_raddr;
   assign o_pkt_bufid_ack_p0 = w_rel_gnt[0];
   assign o_pkt_bufid_ack_p1 = w_rel_gnt[1];
   assign o_free_bufid_wr    = |w_rel_gnt;
   assign ov_free_bufid      = r_free_bufid;
   assign ov_pkt_data_p0     = r_data_p0;
   assign ov_pkt_data_p1     = r_data_p1;
   assign o_pkt_data_wr_p0   = r_data_wr_p0;
   assign o_pkt_data_wr_p1   = r_data_wr_p1;

endmodule

// File: tb/tb_pkt_read_responder.sv
// Directed bench: one RAM_LAT=1 and one RAM_LAT=3 responder share stimulus, each with its own RAM model.
module tb_pkt_read_responder;

   logic         i_clk;
   logic         i_rst_n;
   logic [8:0]   bufid_p0, bufid_p1;
   logic         bufid_wr_p0, bufid_wr_p1;
   logic [15:0]  raddr_p0, raddr_p1;
   logic         rd_p0, rd_p1;

   logic         bufid_ack_p0, bufid_ack_p1, raddr_ack_p0, raddr_ack_p1;
   logic [133:0] data_p0, data_p1, ram_rdata;
   logic         data_wr_p0, data_wr_p1, ram_rd, free_wr;
   logic [15:0]  ram_raddr;
   logic [8:0]   free_bufid;

   logic         bufid_ack_p0_3, bufid_ack_p1_3, raddr_ack_p0_3, raddr_ack_p1_3;
   logic [133:0] data_p0_3, data_p1_3, ram_rdata_3;
   logic         data_wr_p0_3, data_wr_p1_3, ram_rd_3, free_wr_3;
   logic [15:0]  ram_raddr_3;
   logic [8:0]   free_bufid_3;

   int n_pass  = 0;
   int n_total = 0;

   pkt_read_responder #(.RAM_LAT(1)) u_dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .iv_pkt_bufid_p0(bufid_p0), .iv_pkt_bufid_p1(bufid_p1),
      .i_pkt_bufid_wr_p0(bufid_wr_p0), .i_pkt_bufid_wr_p1(bufid_wr_p1),
      .o_pkt_bufid_ack_p0(bufid_ack_p0), .o_pkt_bufid_ack_p1(bufid_ack_p1),
      .iv_pkt_raddr_p0(raddr_p0), .iv_pkt_raddr_p1(raddr_p1),
      .i_pkt_rd_p0(rd_p0), .i_pkt_rd_p1(rd_p1),
      .o_pkt_raddr_ack_p0(raddr_ack_p0), .o_pkt_raddr_ack_p1(raddr_ack_p1),
      .ov_pkt_data_p0(data_p0), .ov_pkt_data_p1(data_p1),
      .o_pkt_data_wr_p0(data_wr_p0), .o_pkt_data_wr_p1(data_wr_p1),
      .ov_ram_raddr(ram_raddr), .o_ram_rd(ram_rd), .iv_ram_rdata(ram_rdata),
      .ov_free_bufid(free_bufid), .o_free_bufid_wr(free_wr)
   );

   pkt_read_responder #(.RAM_LAT(3)) u_dut3 (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .iv_pkt_bufid_p0(bufid_p0), .iv_pkt_bufid_p1(bufid_p1),
      .i_pkt_bufid_wr_p0(bufid_wr_p0), .i_pkt_bufid_wr_p1(bufid_wr_p1),
      .o_pkt_bufid_ack_p0(bufid_ack_p0_3), .o_pkt_bufid_ack_p1(bufid_ack_p1_3),
      .iv_pkt_raddr_p0(raddr_p0), .iv_pkt_raddr_p1(raddr_p1),
      .i_pkt_rd_p0(rd_p0), .i_pkt_rd_p1(rd_p1),
      .o_pkt_raddr_ack_p0(raddr_ack_p0_3), .o_pkt_raddr_ack_p1(raddr_ack_p1_3),
      .ov_pkt_data_p0(data_p0_3), .ov_pkt_data_p1(data_p1_3),
      .o_pkt_data_wr_p0(data_wr_p0_3), .o_pkt_data_wr_p1(data_wr_p1_3),
      .ov_ram_raddr(ram_raddr_3), .o_ram_rd(ram_rd_3), .iv_ram_rdata(ram_rdata_3),
      .ov_free_bufid(free_bufid_3), .o_free_bufid_wr(free_wr_3)
   );

   function automatic logic [133:0] ram_word(input logic [15:0] a);
      return {6'h2A, {8{a}}};
   endfunction

   logic [133:0] ram1_q;
   logic [133:0] ram3_q [3];
   always @(posedge i_clk) begin
      ram1_q    <= ram_rd ? ram_word(ram_raddr) : '0;
      ram3_q[0] <= ram_rd_3 ? ram_word(ram_raddr_3) : '0;
      ram3_q[1] <= ram3_q[0];
      ram3_q[2] <= ram3_q[1];
   end
   assign ram_rdata   = ram1_q;
   assign ram_rdata_3 = ram3_q[2];

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic apply_reset();
      rd_p0 = 0; rd_p1 = 0; bufid_wr_p0 = 0; bufid_wr_p1 = 0;
      i_rst_n = 1'b0;
      tick(); tick();
      i_rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [1:0] acks;
      i_rst_n = 1'b0;
      rd_p0 = 1; raddr_p0 = 16'h1234; bufid_wr_p1 = 1; bufid_p1 = 9'h0AA;
      tick(); tick();
      n_total++;
      if ({raddr_ack_p0, raddr_ack_p1, bufid_ack_p0, bufid_ack_p1, ram_rd, free_wr, data_wr_p0, data_wr_p1} !== 8'h00)
         $display("FAIL reset_strobes: got %b want 00000000", {raddr_ack_p0, raddr_ack_p1, bufid_ack_p0, bufid_ack_p1, ram_rd, free_wr, data_wr_p0, data_wr_p1});
      else n_pass++;
      n_total++;
      if ({ram_raddr, free_bufid, data_p0, data_p1} !== '0)
         $display("FAIL reset_values: raddr %h bufid %h d0 %h d1 %h want all 0", ram_raddr, free_bufid, data_p0, data_p1);
      else n_pass++;
      n_total++;
      if ({raddr_ack_p0_3, raddr_ack_p1_3, bufid_ack_p0_3, bufid_ack_p1_3, ram_rd_3, free_wr_3, data_wr_p0_3, data_wr_p1_3} !== 8'h00)
         $display("FAIL reset_strobes_lat3: got %b want 00000000", {raddr_ack_p0_3, raddr_ack_p1_3, bufid_ack_p0_3, bufid_ack_p1_3, ram_rd_3, free_wr_3, data_wr_p0_3, data_wr_p1_3});
      else n_pass++;
      n_total++;
      if ({ram_raddr_3, free_bufid_3, data_p0_3, data_p1_3} !== '0)
         $display("FAIL reset_values_lat3: raddr %h bufid %h d0 %h d1 %h want all 0", ram_raddr_3, free_bufid_3, data_p0_3, data_p1_3);
      else n_pass++;
      rd_p0 = 0; bufid_wr_p1 = 0;
      i_rst_n = 1'b1;
      tick();
      acks = {raddr_ack_p0, bufid_ack_p1};
      n_total++;
      if (acks !== 2'b00) $display("FAIL reset_no_late_ack: got %b want 00", acks);
      else n_pass++;
   endtask

   task automatic test_single_read();
      rd_p0 = 1; raddr_p0 = 16'h0010;
      tick();                                   // T+1
      n_total++;
      if ({raddr_ack_p0, raddr_ack_p1, ram_rd} !== 3'b101)
         $display("FAIL single_grant: ack0/ack1/rd got %b want 101", {raddr_ack_p0, raddr_ack_p1, ram_rd});
      else n_pass++;
      n_total++;
      if (ram_raddr !== 16'h0010) $display("FAIL single_raddr: got %h want 0010", ram_raddr);
      else n_pass++;
      tick();                                   // T+2
      rd_p0 = 0;
      n_total++;
      if ({raddr_ack_p0, data_wr_p0} !== 2'b00)
         $display("FAIL single_t2: ack/wr got %b want 00", {raddr_ack_p0, data_wr_p0});
      else n_pass++;
      tick();                                   // T+3
      n_total++;
      if (data_wr_p0 !== 1'b1 || data_p0 !== ram_word(16'h0010))
         $display("FAIL single_data: wr %b data %h want 1 %h", data_wr_p0, data_p0, ram_word(16'h0010));
      else n_pass++;
      n_total++;
      if (data_wr_p0_3 !== 1'b0) $display("FAIL lat3_early: wr got %b want 0 at T+3", data_wr_p0_3);
      else n_pass++;
      tick();                                   // T+4
      n_total++;
      if ({data_wr_p0, data_wr_p0_3} !== 2'b00)
         $display("FAIL single_t4: wr/wr3 got %b want 00", {data_wr_p0, data_wr_p0_3});
      else n_pass++;
      tick();                                   // T+5
      n_total++;
      if (data_wr_p0_3 !== 1'b1 || data_p0_3 !== ram_word(16'h0010))
         $display("FAIL lat3_data: wr %b data %h want 1 %h", data_wr_p0_3, data_p0_3, ram_word(16'h0010));
      else n_pass++;
      tick();                                   // T+6
      n_total++;
      if ({data_wr_p0, data_wr_p0_3, data_wr_p1, data_wr_p1_3} !== 4'b0000)
         $display("FAIL single_one_pulse: got %b want 0000", {data_wr_p0, data_wr_p0_3, data_wr_p1, data_wr_p1_3});
      else n_pass++;
   endtask

   task automatic test_contention();
      logic        e0, e1, d0, d1;
      logic [15:0] ea;
      apply_reset();
      rd_p0 = 1; rd_p1 = 1; raddr_p0 = 16'h0100; raddr_p1 = 16'h0200;
      for (int c = 0; c < 10; c++) begin
         tick();
         e0 = (c < 8) && (c % 2 == 0);
         e1 = (c < 8) && (c % 2 == 1);
         n_total++;
         if ({raddr_ack_p0, raddr_ack_p1, ram_rd} !== {e0, e1, e0 | e1})
            $display("FAIL contend_ack c%0d: ack0/ack1/rd got %b want %b", c, {raddr_ack_p0, raddr_ack_p1, ram_rd}, {e0, e1, e0 | e1});
         else n_pass++;
         if (e0 || e1) begin
            ea = (e0 ? 16'h0100 : 16'h0200) + 16'(c / 2);
            n_total++;
            if (ram_raddr !== ea) $display("FAIL contend_raddr c%0d: got %h want %h", c, ram_raddr, ea);
            else n_pass++;
         end
         d0 = (c >= 2) && (c % 2 == 0);
         d1 = (c >= 3) && (c % 2 == 1);
         n_total++;
         if ({data_wr_p0, data_wr_p1} !== {d0, d1})
            $display("FAIL contend_wr c%0d: wr0/wr1 got %b want %b", c, {data_wr_p0, data_wr_p1}, {d0, d1});
         else n_pass++;
         if (d0 || d1) begin
            ea = d0 ? 16'h0100 + 16'((c - 2) / 2) : 16'h0200 + 16'((c - 3) / 2);
            n_total++;
            if ((d0 ? data_p0 : data_p1) !== ram_word(ea))
               $display("FAIL contend_data c%0d: got %h want %h", c, d0 ? data_p0 : data_p1, ram_word(ea));
            else n_pass++;
         end
         if (e0) raddr_p0 = raddr_p0 + 16'd1;
         if (e1) raddr_p1 = raddr_p1 + 16'd1;
         if (c == 7) begin rd_p0 = 0; rd_p1 = 0; end
      end
   endtask

   task automatic test_stream_p1();
      logic        e1, d1;
      logic [15:0] ea;
      rd_p1 = 1; raddr_p1 = 16'h0300;
      for (int c = 0; c < 10; c++) begin
         tick();
         e1 = (c < 8) && (c % 2 == 0);
         d1 = (c >= 2) && (c <= 8) && (c % 2 == 0);
         n_total++;
         if ({raddr_ack_p0, raddr_ack_p1} !== {1'b0, e1})
            $display("FAIL stream_ack c%0d: ack0/ack1 got %b want %b", c, {raddr_ack_p0, raddr_ack_p1}, {1'b0, e1});
         else n_pass++;
         if (e1) begin
            ea = 16'h0300 + 16'(c / 2);
            n_total++;
            if (ram_raddr !== ea) $display("FAIL stream_raddr c%0d: got %h want %h", c, ram_raddr, ea);
            else n_pass++;
         end
         n_total++;
         if ({data_wr_p0, data_wr_p1} !== {1'b0, d1})
            $display("FAIL stream_wr c%0d: wr0/wr1 got %b want %b", c, {data_wr_p0, data_wr_p1}, {1'b0, d1});
         else n_pass++;
         if (d1) begin
            ea = 16'h0300 + 16'((c - 2) / 2);
            n_total++;
            if (data_p1 !== ram_word(ea)) $display("FAIL stream_data c%0d: got %h want %h", c, data_p1, ram_word(ea));
            else n_pass++;
         end
         if (e1) raddr_p1 = raddr_p1 + 16'd1;
         if (c == 7) rd_p1 = 0;
      end
   endtask

   task automatic test_release();
      bufid_p0 = 9'h1FF; bufid_wr_p0 = 1; bufid_p1 = 9'h005; bufid_wr_p1 = 1;
      rd_p0 = 1; raddr_p0 = 16'h0400;
      tick();
      n_total++;
      if ({bufid_ack_p0, bufid_ack_p1, free_wr} !== 3'b101 || free_bufid !== 9'h1FF)
         $display("FAIL release_first: ack0/ack1/wr %b bufid %h want 101 1ff", {bufid_ack_p0, bufid_ack_p1, free_wr}, free_bufid);
      else n_pass++;
      n_total++;
      if ({raddr_ack_p0, ram_rd} !== 2'b11 || ram_raddr !== 16'h0400)
         $display("FAIL release_read_indep: ack/rd %b raddr %h want 11 0400", {raddr_ack_p0, ram_rd}, ram_raddr);
      else n_pass++;
      bufid_wr_p0 = 0; rd_p0 = 0;
      tick();
      n_total++;
      if ({bufid_ack_p0, bufid_ack_p1, free_wr} !== 3'b011 || free_bufid !== 9'h005)
         $display("FAIL release_second: ack0/ack1/wr %b bufid %h want 011 005", {bufid_ack_p0, bufid_ack_p1, free_wr}, free_bufid);
      else n_pass++;
      n_total++;
      if (ram_rd !== 1'b0 || ram_raddr !== 16'h0400)
         $display("FAIL raddr_hold: rd %b raddr %h want 0 0400", ram_rd, ram_raddr);
      else n_pass++;
      bufid_wr_p1 = 0;
      tick();
      n_total++;
      if ({bufid_ack_p0, bufid_ack_p1, free_wr} !== 3'b000 || free_bufid !== 9'h005)
         $display("FAIL bufid_hold: ack0/ack1/wr %b bufid %h want 000 005", {bufid_ack_p0, bufid_ack_p1, free_wr}, free_bufid);
      else n_pass++;
      n_total++;
      if (data_wr_p0 !== 1'b1 || data_p0 !== ram_word(16'h0400))
         $display("FAIL release_read_data: wr %b data %h want 1 %h", data_wr_p0, data_p0, ram_word(16'h0400));
      else n_pass++;
      tick();
      n_total++;
      if (data_wr_p0 !== 1'b0 || data_p0 !== ram_word(16'h0400))
         $display("FAIL data_hold: wr %b data %h want 0 %h", data_wr_p0, data_p0, ram_word(16'h0400));
      else n_pass++;
   endtask

   task automatic test_reset_midflight();
      rd_p1 = 1; raddr_p1 = 16'h0500;
      tick();                                   // grant cycle
      n_total++;
      if (raddr_ack_p1 !== 1'b1) $display("FAIL midflight_grant: ack1 got %b want 1", raddr_ack_p1);
      else n_pass++;
      rd_p1 = 0;
      tick();
      i_rst_n = 1'b0;
      tick();
      n_total++;
      if ({data_wr_p0, data_wr_p1, ram_rd, free_wr, data_wr_p1_3} !== 5'b00000)
         $display("FAIL midflight_strobes: got %b want 00000", {data_wr_p0, data_wr_p1, ram_rd, free_wr, data_wr_p1_3});
      else n_pass++;
      n_total++;
      if ({ram_raddr, free_bufid, data_p0, data_p1} !== '0)
         $display("FAIL midflight_values: raddr %h bufid %h d0 %h d1 %h want all 0", ram_raddr, free_bufid, data_p0, data_p1);
      else n_pass++;
      i_rst_n = 1'b1;
      rd_p0 = 1; raddr_p0 = 16'h0600; rd_p1 = 1; raddr_p1 = 16'h0601;
      tick();
      n_total++;
      if ({raddr_ack_p0, raddr_ack_p1, data_wr_p1, data_wr_p1_3} !== 4'b1000)
         $display("FAIL post_reset_first: ack0/ack1/wr1/wr1_3 got %b want 1000", {raddr_ack_p0, raddr_ack_p1, data_wr_p1, data_wr_p1_3});
      else n_pass++;
      rd_p0 = 0;
      tick();
      n_total++;
      if ({raddr_ack_p0, raddr_ack_p1, data_wr_p1_3} !== 3'b010 || ram_raddr !== 16'h0601)
         $display("FAIL post_reset_second: ack0/ack1/wr1_3 %b raddr %h want 010 0601", {raddr_ack_p0, raddr_ack_p1, data_wr_p1_3}, ram_raddr);
      else n_pass++;
      rd_p1 = 0;
      tick();
      n_total++;
      if ({data_wr_p0, data_wr_p1} !== 2'b10 || data_p0 !== ram_word(16'h0600))
         $display("FAIL post_reset_d0: wr0/wr1 %b data %h want 10 %h", {data_wr_p0, data_wr_p1}, data_p0, ram_word(16'h0600));
      else n_pass++;
      tick();
      n_total++;
      if ({data_wr_p0, data_wr_p1} !== 2'b01 || data_p1 !== ram_word(16'h0601))
         $display("FAIL post_reset_d1: wr0/wr1 %b data %h want 01 %h", {data_wr_p0, data_wr_p1}, data_p1, ram_word(16'h0601));
      else n_pass++;
   endtask

   initial begin
      i_rst_n = 1'b0;
      bufid_p0 = '0; bufid_p1 = '0; bufid_wr_p0 = 0; bufid_wr_p1 = 0;
      raddr_p0 = '0; raddr_p1 = '0; rd_p0 = 0; rd_p1 = 0;
      test_reset();
      test_single_read();
      test_contention();
      test_stream_p1();
      test_release();
      test_reset_midflight();
      repeat (6) tick();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pkt_read_responder.md
PKT_READ_RESPONDER -- requirements
Module: pkt_read_responder

Interface
REQ-001 Parameter RAM_LAT, default 1, is the packet-RAM read latency in cycles (legal 1..3).
REQ-002 i_clk  in  1  the only clock; all logic is in this domain.
REQ-003 i_rst_n  in  1  reset, synchronous and active-low.
REQ-004 iv_pkt_bufid_p0/p1  in  9  bufid released by transmit port 0/1.
REQ-005 i_pkt_bufid_wr_p0/p1  in  1  release request; held high until acked.
REQ-006 o_pkt_bufid_ack_p0/p1  out  1  one-cycle acceptance pulse for the release.
REQ-007 iv_pkt_raddr_p0/p1  in  16  packet-RAM word address requested by port 0/1.
REQ-008 i_pkt_rd_p0/p1  in  1  read request; held high until acked.
REQ-009 o_pkt_raddr_ack_p0/p1  out  1  one-cycle read-grant pulse.
REQ-010 ov_pkt_data_p0/p1  out  134  returned RAM word for port 0/1.
REQ-011 o_pkt_data_wr_p0/p1  out  1  one-cycle valid for ov_pkt_data_pN.
REQ-012 ov_ram_raddr  out  16  address to the shared packet RAM.
REQ-013 o_ram_rd  out  1  RAM read strobe.
REQ-014 iv_ram_rdata  in  134  RAM data, valid RAM_LAT cycles after o_ram_rd.
REQ-015 ov_free_bufid  out  9  bufid forwarded to the buffer free-list.
REQ-016 o_free_bufid_wr  out  1  one-cycle write pulse; the free-list accepts every cycle.

Function
REQ-017 Read arbitration: round-robin between p0/p1 with the priority pointer set to the port not granted last; only one RAM read is issued per cycle.
REQ-018 A request sampled in cycle T that wins the arbitration produces, in T+1, o_pkt_raddr_ack_pN=1, o_ram_rd=1 and ov_ram_raddr set to the sampled address.
REQ-019 A port acked in cycle T+1 is masked from arbitration in T+1; the requester drops or changes i_pkt_rd in T+2, so no request is granted twice.
REQ-020 The port id travels in a RAM_LAT-deep tag pipeline alongside each read; at T+1+RAM_LAT, iv_ram_rdata is registered into ov_pkt_data_pN and o_pkt_data_wr_pN=1 in T+2+RAM_LAT (total latency 2+RAM_LAT from request sample to data).
REQ-021 Data is returned in grant order, and exactly one data pulse is produced per ack.
REQ-022 ov_pkt_data_pN holds its last value when o_pkt_data_wr_pN=0.
REQ-023 Throughput: alternating ports sustain one read per cycle; a single port sustains one read every 2 cycles.
REQ-024 Bufid release uses an independent round-robin arbiter of the same form: the winner sampled in T gets o_pkt_bufid_ack_pN=1 in T+1, with ov_free_bufid=bufid and o_free_bufid_wr=1 in T+1; the port just acked is masked in T+1.
REQ-025 Simultaneous read and release requests from the same port are serviced independently.
REQ-026 ov_ram_raddr and ov_free_bufid hold their last value when the strobe is 0.

Reset
REQ-027 While i_rst_n=0 at a clock edge, all ack, wr and rd strobes are 0, the data, address and bufid outputs are 0, both round-robin pointers favour p0, and the tag pipeline is cleared.
REQ-028 Reads in flight when reset asserts are discarded, with no data pulse after reset; the requester reissues them.

Structure
REQ-029 The shared package holds the width constants: bufid 9, raddr 16, data 134, and the port count 2.
REQ-030 One sub-module, rr_arb2, provides 2-way round-robin with a last-grant mask; it is instantiated twice, once for reads and once for releases.

Verification
REQ-031 Single read: p0 requests addr 0x0010 at T, RAM returns 0xAA.. → ack_p0 at T+1, o_ram_rd with 0x0010 at T+1, data_wr_p0 with 0xAA.. at T+3 (RAM_LAT=1).
REQ-032 Contention: p0 and p1 both request continuously from reset → grants alternate p0, p1, p0, …, one per cycle, and the data returns to the correct port in order.
REQ-033 Single-port streaming: only p1 requests, holding rd high and updating the address after each ack → acks every 2nd cycle, and no duplicate grant.
REQ-034 Release: p0 bufid 0x1FF and p1 bufid 0x005 both requested in the same cycle → two free_bufid pulses on consecutive cycles, in round-robin order, each acked once.
REQ-035 Reset mid-flight: i_rst_n low one cycle after a grant → no data_wr pulse appears, all outputs are 0, and the first post-reset grant goes to p0.
REQ-036 RAM_LAT=3 build: REQ-031 stimulus → data_wr_p0 at T+5.
